// File: rtl/pulse_tx_pkg.sv
// Shared types and sizing helpers for the pulse transmitter.
package pulse_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Phase counter must hold the longer of the high and low phase lengths.
  function automatic int unsigned phase_w(input int unsigned high_cyc,
                                          input int unsigned low_cyc);
    int unsigned longest;
    longest = (high_cyc > low_cyc) ? high_cyc : low_cyc;
    return $unsigned($clog2(longest + 1));
  endfunction

endpackage

// File: rtl/pend_sat_counter.sv
// Saturating up/down counter of queued events with an overflow strobe.
module pend_sat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow_c
);

  localparam logic [W-1:0] MAX = '1;

  assign overflow_c = inc & ~dec & (count == MAX);

  // Simultaneous inc and dec cancel; inc at MAX is dropped.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && !dec && (count != MAX)) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pulse_tx.sv
// Converts event strobes into spaced, fixed-width level pulses with queuing.
module pulse_tx
  import pulse_tx_pkg::*;
#(
  parameter int unsigned HIGH_CYC = 4,
  parameter int unsigned LOW_CYC  = 4,
  parameter int unsigned PEND_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evt,
  input  logic              clr_ovf,
  output logic              sig_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  localparam int unsigned     PH_W      = phase_w(HIGH_CYC, LOW_CYC);
  localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_CYC - 1);
  localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_CYC - 1);

  state_t            state;
  state_t            state_d;
  logic [PH_W-1:0]   phase;
  logic [PH_W-1:0]   phase_d;
  logic              sig_d;
  logic              busy_d;
  logic              consume_c;
  logic              inc_c;
  logic              ovf_strobe_c;

  // Next state, phase and registered-output values.
  always_comb begin
    state_d   = state;
    phase_d   = phase;
    consume_c = 1'b0;
    case (state)
      IDLE: begin
        if (evt) begin
          state_d = HIGH;
          phase_d = '0;
        end
      end
      HIGH: begin
        if (phase == HIGH_LAST) begin
          state_d = LOW;
          phase_d = '0;
        end else begin
          phase_d = phase + PH_W'(1);
        end
      end
      LOW: begin
        if (phase == LOW_LAST) begin
          phase_d = '0;
          if ((pend != '0) || evt) begin
            state_d   = HIGH;
            consume_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          phase_d = phase + PH_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
    sig_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  // In IDLE the event starts a pulse directly and never enters the queue.
  assign inc_c = evt && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      phase   <= '0;
      sig_out <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_d;
      phase   <= phase_d;
      sig_out <= sig_d;
      busy    <= busy_d;
      if (ovf_strobe_c) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  pend_sat_counter #(
    .W (PEND_W)
  ) u_pend (
    .clk        (clk),
    .clr        (!rst_n),
    .inc        (inc_c),
    .dec        (consume_c),
    .count      (pend),
    .overflow_c (ovf_strobe_c)
  );

endmodule

// File: tb/tb_pulse_tx.sv
// Self-checking bench: timeline model, directed vectors and receiver loopback.
module tb_pulse_tx;

  localparam int H    = 4;
  localparam int L    = 4;
  localparam int PW   = 3;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          evt = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          sig_out;
  logic          busy;
  logic [PW-1:0] pend;
  logic          ovf;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  pulse_tx #(
    .HIGH_CYC (H),
    .LOW_CYC  (L),
    .PEND_W   (PW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .evt     (evt),
    .clr_ovf (clr_ovf),
    .sig_out (sig_out),
    .busy    (busy),
    .pend    (pend),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Model: position within the current pulse+gap timeline (0 = idle).
  int m_pos = 0;
  int m_pend = 0;
  bit m_ovf = 1'b0;
  int m_starts = 0;

  always @(posedge clk) begin : model
    int  np;
    int  nq;
    bit  cons;
    bit  drop;
    if (!rst_n) begin
      m_pos  <= 0;
      m_pend <= 0;
      m_ovf  <= 1'b0;
    end else begin
      cons = (m_pos == H + L) && ((m_pend > 0) || evt);
      if (m_pos == 0)          np = evt ? 1 : 0;
      else if (m_pos == H + L) np = cons ? 1 : 0;
      else                     np = m_pos + 1;
      nq   = m_pend;
      drop = 1'b0;
      if (evt && m_pos != 0) begin
        if (!cons) begin
          if (m_pend == PMAX) drop = 1'b1;
          else                nq = m_pend + 1;
        end
      end else if (cons) begin
        nq = m_pend - 1;
      end
      m_pos  <= np;
      m_pend <= nq;
      if (drop)         m_ovf <= 1'b1;
      else if (clr_ovf) m_ovf <= 1'b0;
      if (np == 1 && (m_pos == 0 || cons)) m_starts <= m_starts + 1;
    end
  end

  // Receiver side: 3-flop synchronizer and rising-edge detector.
  logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  int   rises = 0;
  always @(posedge clk) begin
    s0 <= sig_out;
    s1 <= s0;
    s2 <= s1;
    if (s1 && !s2) rises <= rises + 1;
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks += 4;
      if (sig_out !== (m_pos >= 1 && m_pos <= H)) begin
        errors++;
        $display("FAIL model_sig t=%0t got %0b want %0b", $time, sig_out, (m_pos >= 1 && m_pos <= H));
      end
      if (busy !== (m_pos != 0)) begin
        errors++;
        $display("FAIL model_busy t=%0t got %0b want %0b", $time, busy, (m_pos != 0));
      end
      if (pend !== PW'(m_pend)) begin
        errors++;
        $display("FAIL model_pend t=%0t got %0d want %0d", $time, pend, m_pend);
      end
      if (ovf !== m_ovf) begin
        errors++;
        $display("FAIL model_ovf t=%0t got %0b want %0b", $time, ovf, m_ovf);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  logic [127:0] pat;
  logic [127:0] cpat;
  logic [127:0] rpat;
  int sig_h  [0:127];
  int busy_h [0:127];
  int pend_h [0:127];
  int ovf_h  [0:127];
  int r0;
  int st0;

  task automatic do_reset();
    rst_n   = 1'b0;
    evt     = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pat  = '0;
    cpat = '0;
    rpat = '0;
    r0   = rises;
    st0  = m_starts;
  endtask

  // Drive pattern bit k before edge k; history index k+1 holds the cycle after.
  task automatic run(input int n);
    sig_h[0]  = int'(sig_out);
    busy_h[0] = int'(busy);
    pend_h[0] = int'(pend);
    ovf_h[0]  = int'(ovf);
    for (int k = 0; k < n; k++) begin
      evt     = pat[k];
      clr_ovf = cpat[k];
      rst_n   = !rpat[k];
      @(negedge clk);
      sig_h[k+1]  = int'(sig_out);
      busy_h[k+1] = int'(busy);
      pend_h[k+1] = int'(pend);
      ovf_h[k+1]  = int'(ovf);
    end
    evt     = 1'b0;
    clr_ovf = 1'b0;
    rst_n   = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    chk("rst_sig", int'(sig_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_ovf", int'(ovf), 0);

    // Single event.
    pat[0] = 1'b1;
    run(14);
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("t1_sig_c%0d", k), sig_h[k], (k <= 4) ? 1 : 0);
      chk($sformatf("t1_busy_c%0d", k), busy_h[k], (k <= 8) ? 1 : 0);
      chk($sformatf("t1_pend_c%0d", k), pend_h[k], 0);
    end
    chk("t1_rises", rises - r0, 1);

    // Three back-to-back events queue up.
    do_reset();
    pat[2:0] = 3'b111;
    run(30);
    chk("t2_pend_c2", pend_h[2], 1);
    chk("t2_pend_c3", pend_h[3], 2);
    chk("t2_pend_c9", pend_h[9], 1);
    chk("t2_pend_c17", pend_h[17], 0);
    chk("t2_sig_c9", sig_h[9], 1);
    chk("t2_sig_c12", sig_h[12], 1);
    chk("t2_sig_c13", sig_h[13], 0);
    chk("t2_sig_c17", sig_h[17], 1);
    chk("t2_sig_c20", sig_h[20], 1);
    chk("t2_busy_c24", busy_h[24], 1);
    chk("t2_busy_c25", busy_h[25], 0);
    chk("t2_rises", rises - r0, 3);

    // Held evt: saturation, overflow on the first non-consume cycle at max.
    do_reset();
    pat[9:0] = 10'h3FF;
    run(80);
    chk("t3_pend_c8", pend_h[8], 7);
    chk("t3_pend_c9", pend_h[9], 7);
    chk("t3_ovf_c9", ovf_h[9], 0);
    chk("t3_ovf_c10", ovf_h[10], 1);
    chk("t3_ovf_c80", ovf_h[80], 1);
    chk("t3_busy_c80", busy_h[80], 0);
    chk("t3_rises", rises - r0, 9);
    chk("t3_loop", rises - r0, m_starts - st0);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", int'(ovf), 0);

    // Event on the last gap cycle restarts without an idle cycle.
    do_reset();
    pat[0] = 1'b1;
    pat[8] = 1'b1;
    run(22);
    chk("t4_sig_c8", sig_h[8], 0);
    for (int k = 9; k <= 12; k++) chk($sformatf("t4_sig_c%0d", k), sig_h[k], 1);
    chk("t4_busy_c9", busy_h[9], 1);
    for (int k = 0; k <= 22; k++) chk($sformatf("t4_pend_c%0d", k), pend_h[k], 0);
    chk("t4_rises", rises - r0, 2);

    // Reset mid-pulse with queued events.
    do_reset();
    pat[3:0] = 4'hF;
    rpat[4]  = 1'b1;
    run(30);
    chk("t5_pend_c4", pend_h[4], 3);
    chk("t5_sig_c5", sig_h[5], 0);
    chk("t5_busy_c5", busy_h[5], 0);
    chk("t5_pend_c5", pend_h[5], 0);
    chk("t5_busy_c30", busy_h[30], 0);
    chk("t5_rises", rises - r0, 1);

    // Overflow and clear in the same cycle: set wins.
    do_reset();
    pat[9:0] = 10'h3FF;
    cpat[9]  = 1'b1;
    cpat[10] = 1'b1;
    run(80);
    chk("t6_ovf_c10", ovf_h[10], 1);
    chk("t6_ovf_c11", ovf_h[11], 0);
    chk("t6_rises", rises - r0, 9);
    chk("t6_loop", rises - r0, m_starts - st0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
